// File: rtl/dcm_prog_ctrl_if.sv
// Operator/clock-manager signal bundle for the programming-port front end.
interface dcm_prog_ctrl_if;
  logic       btn_update;
  logic [2:0] sw_prog;
  logic [2:0] prog_out_fb;
  logic [2:0] prog_in;
  logic       update;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output btn_update, sw_prog, prog_out_fb,
    input  prog_in, update, busy, done, error
  );

  modport slave (
    input  btn_update, sw_prog, prog_out_fb,
    output prog_in, update, busy, done, error
  );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// Debounced "apply" button front end: latches the rate switches, pulses update
// to the clock manager, then checks prog_out for a match or times out.
module dcm_prog_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ACK_TIMEOUT     = 16
) (
  input  logic            clk,
  input  logic            rst,
  dcm_prog_ctrl_if.slave  bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PULSE, S_CHECK, S_WAIT_REL
  } state_e;

  logic            btn_meta_q, btn_sync_q;
  logic [2:0]      sw_meta_q, sw_sync_q;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q;
  logic            armed_q, armed_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  state_e          state_q, state_d;
  logic [2:0]      prog_in_q, prog_in_d;
  logic            update_q, update_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            db_ref;
  logic            press;
  logic            fb_match;

  // Until a qualified low has been seen since reset, the debouncer hunts for a
  // stable release instead of a press, so a button held through reset cannot
  // produce a btn_db rise.
  always_comb begin
    btn_db_d = btn_db_q;
    armed_d  = armed_q;
    db_cnt_d = db_cnt_q;
    db_ref   = armed_q ? btn_db_q : 1'b1;
    if (btn_sync_q == db_ref) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      if (armed_q) btn_db_d = btn_sync_q;
      else         armed_d  = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  assign press    = btn_db_q & ~btn_db_prev_q;
  assign fb_match = (bus.prog_out_fb == prog_in_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    prog_in_d = prog_in_q;
    update_d  = 1'b0;
    done_d    = 1'b0;
    error_d   = error_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_LOAD;
      end
      S_LOAD: begin
        prog_in_d = sw_sync_q;
        state_d   = S_PULSE;
      end
      S_PULSE: begin
        update_d = 1'b1;
        to_cnt_d = '0;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (fb_match) begin
          done_d  = 1'b1;
          error_d = 1'b0;
          state_d = S_WAIT_REL;
        end else if (to_cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!btn_db_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      sw_meta_q     <= 3'b000;
      sw_sync_q     <= 3'b000;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      armed_q       <= 1'b0;
      db_cnt_q      <= '0;
      to_cnt_q      <= '0;
      state_q       <= S_IDLE;
      prog_in_q     <= 3'b000;
      update_q      <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      btn_meta_q    <= bus.btn_update;
      btn_sync_q    <= btn_meta_q;
      sw_meta_q     <= bus.sw_prog;
      sw_sync_q     <= sw_meta_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      armed_q       <= armed_d;
      db_cnt_q      <= db_cnt_d;
      to_cnt_q      <= to_cnt_d;
      state_q       <= state_d;
      prog_in_q     <= prog_in_d;
      update_q      <= update_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign bus.prog_in = prog_in_q;
  assign bus.update  = update_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule
